// File: rtl/seg7_pkg.sv
// seg7_pkg: register offsets, FSM encoding, hex font and output reset values
package seg7_pkg;
    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_CTRL   = 2'd1;
    localparam logic [1:0] OFS_STATUS = 2'd2;
    localparam logic [1:0] OFS_RSVD   = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_ON} state_t;

    // index 0 is the least significant element: entries listed F down to 0
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_RST  = 7'h00;
    localparam logic [3:0] COMM_RST = 4'hF;
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: picosoc iomem bus bundle with master/slave views
interface seg7_scan_ctrl_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: 4-bit hex nibble to active-high segments g..a
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: iomem-mapped 4-digit seven-segment scanner; SEG7_DIM_EN adds PWM dimming
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0300_0100,
    parameter int          DIGIT_CYCLES = 12000,
    parameter int          BLANK_CYCLES = 48
) (
    input  logic            clk,
    input  logic            resetn,
    seg7_scan_ctrl_if.slave bus,
    output logic [6:0]      seg,
    output logic [3:0]      comm
);
    localparam int            CW         = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n, ofs;
    logic [15:0]   data_r, shadow_data;
    logic [3:0]    mask_r, shadow_mask, duty_r, comm_n, nib;
    logic [6:0]    dec_seg, seg_n;
    logic [31:0]   rd_val;
    logic          en_r, load, hit, wr, lit, unused_bits;

    assign unused_bits = ^{bus.iomem_wstrb[3:2], bus.iomem_addr[1:0], bus.iomem_wdata[31:16]};
    assign ofs    = bus.iomem_addr[3:2];
    assign hit    = bus.iomem_valid && !bus.iomem_ready && bus.iomem_addr[31:4] == BASE_ADDR[31:4];
    assign wr     = hit && |bus.iomem_wstrb;
    assign rd_val = ofs == OFS_RSVD   ? 32'h0 :
                    ofs == OFS_STATUS ? {29'h0, state == ST_ON, idx} :
                    ofs == OFS_CTRL   ? {20'h0, duty_r, mask_r, 3'b0, en_r} :
                    ofs == OFS_DATA   ? {16'h0, data_r} : 32'h0;

`ifdef SEG7_DIM_EN
    logic [3:0] pwm;
    // PWM phase restarts at the beginning of every ON phase
    always_ff @(posedge clk) begin
        if (!resetn) pwm <= 4'd0;
        else         pwm <= state == ST_ON ? pwm + 4'd1 : 4'd0;
    end
    assign lit = pwm <= duty_r;
`else
    assign duty_r = 4'h0;
    assign lit    = 1'b1;
`endif

    // single-cycle acknowledge with pre-write read data, byte-lane register writes
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.iomem_ready <= 1'b0;
            bus.iomem_rdata <= 32'h0;
            data_r          <= 16'h0;
            en_r            <= 1'b0;
            mask_r          <= 4'h0;
`ifdef SEG7_DIM_EN
            duty_r          <= 4'h0;
`endif
        end else begin
            bus.iomem_ready <= hit;
            if (hit) bus.iomem_rdata <= rd_val;
            if (wr && ofs == OFS_DATA && bus.iomem_wstrb[0]) data_r[7:0] <= bus.iomem_wdata[7:0];
            if (wr && ofs == OFS_DATA && bus.iomem_wstrb[1]) data_r[15:8] <= bus.iomem_wdata[15:8];
            if (wr && ofs == OFS_CTRL && bus.iomem_wstrb[0]) {mask_r, en_r} <= {bus.iomem_wdata[7:4], bus.iomem_wdata[0]};
`ifdef SEG7_DIM_EN
            if (wr && ofs == OFS_CTRL && bus.iomem_wstrb[1]) duty_r <= bus.iomem_wdata[11:8];
`endif
        end
    end

    // next state: slot counter, digit advance on wrap, shadow load on slot start
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        load    = 1'b0;
        if (!en_r) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else if (state == ST_IDLE) begin
            state_n = ST_BLANK;
            cnt_n   = '0;
            load    = 1'b1;
        end else if (cnt == CNT_LAST) begin
            state_n = ST_BLANK;
            cnt_n   = '0;
            idx_n   = idx + 2'd1;
            load    = 1'b1;
        end else if (state == ST_BLANK && cnt == BLANK_LAST) begin
            state_n = ST_ON;
        end
    end

    // state register; the shadow only changes at slot boundaries so digits never tear
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shadow_data <= 16'h0;
            shadow_mask <= 4'h0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            if (load) {shadow_data, shadow_mask} <= {data_r, mask_r};
        end
    end

    assign nib = shadow_data[{idx, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    // pin values for the current state; the segments are pre-driven during BLANK
    always_comb begin
        seg_n  = state == ST_IDLE ? SEG_RST : dec_seg;
        comm_n = (state == ST_ON && !shadow_mask[idx] && lit) ? ~(4'b0001 << idx) : COMM_RST;
    end

    // output registers keep the pins glitch-free
    always_ff @(posedge clk) begin
        if (!resetn) begin
            seg  <= SEG_RST;
            comm <= COMM_RST;
        end else begin
            seg  <= seg_n;
            comm <= comm_n;
        end
    end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- iomem-mapped four-digit seven-segment controller on the picosoc iomem bus, in the same window as the GPIO register.
- Replaces the direct GPIO bit-banging of SEG/COMM: firmware writes a 16-bit hex value once, and the block time-multiplexes the digits in hardware.
- Drives the board SEG[6:0] (active-high segments) and COMM[3:0] (active-low digit commons) pins directly.

Parameters:
- BASE_ADDR, 32'h0300_0100, iomem base; the block decodes addr[31:4] == BASE_ADDR[31:4].
- DIGIT_CYCLES, 12000, clk cycles per digit slot (1 ms at 12 MHz); must be >= BLANK_CYCLES+2.
- BLANK_CYCLES, 48, cycles at the start of each slot with all commons off (anti-ghosting).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- iomem_valid  in  1  bus request
- iomem_ready  out  1  one-cycle acknowledge
- iomem_wstrb  in  4  byte write strobes; 0 = read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready=1
- seg  out  7  segments g..a = [6:0], 1 = lit
- comm  out  4  digit commons, 0 = digit on; comm[0] = rightmost digit

Behaviour:
- Reset (resetn=0 at posedge): iomem_ready=0, iomem_rdata=0, seg=7'h00, comm=4'hF, DATA=0, CTRL=0, shadow=0, digit index=0, slot counter=0, state=IDLE. Reset asserted mid-slot or mid-transaction aborts immediately; no pending ack survives.
- Register map (offset = addr[3:2]):
  - 0 DATA: [15:0], four hex nibbles; nibble k shows on digit k. Bits [31:16] are read as 0 and writes to them are ignored.
  - 1 CTRL: [0] EN, [7:4] BLANK_MASK (1 = digit k dark), [11:8] DUTY (feature only).
  - 2 STATUS: read-only, [1:0] digit index, [2] state==ON.
  - 3 reserved: reads return 0, writes are ignored.
- Bus: if iomem_valid && !iomem_ready && address hit, then the next cycle has iomem_ready=1 and rdata holds the pre-write register value; byte lanes are applied per wstrb. iomem_ready is a single-cycle pulse. A miss leaves ready=0 and rdata holds its previous value.
- Slot counter runs 0..DIGIT_CYCLES-1, then wraps to 0; the digit index advances 0→1→2→3→0 on each wrap.
- The shadow copy of DATA and BLANK_MASK is latched only when the counter wraps, so a display never tears mid-slot. A write and a wrap in the same cycle latch the old value; the new value appears from the next slot.
- FSM:
  - IDLE: comm=F, seg=0, counter held at 0. EN=1 → BLANK; the shadow is loaded on entry.
  - BLANK: comm=F, seg=decode(next nibble). When counter==BLANK_CYCLES-1 → ON.
  - ON: comm=~(1<<idx), or F if the digit is masked; seg=decode(shadow nibble idx). On wrap → BLANK with idx+1.
  - EN=0 in any state → IDLE next cycle; idx and counter are reset to 0.
- All of seg and comm are registered: outputs lag the state by exactly 1 cycle.
- Hex decode (a..g): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.

Optional Feature:
- Macro: SEG7_DIM_EN.
- Defined: a 4-bit free-running PWM counter runs within the ON state. comm is active only while pwm <= DUTY, giving duty (DUTY+1)/16; DUTY=F is full brightness. CTRL[11:8] is read/write.
- Undefined: CTRL[11:8] reads 0 and writes are ignored; the ON state is always fully lit.

Decomposition:
- Package seg7_pkg holds:
  - Register offset constants.
  - State encoding (IDLE/BLANK/ON).
  - The 16-entry hex-to-segment constant table.
  - Reset values for comm and seg.
- One combinational sub-module, seg7_hex_decode (4-bit in, 7-bit out), instantiated once.

Test Plan (bench uses DIGIT_CYCLES=16, BLANK_CYCLES=2):
- Reset, then write CTRL=1 and DATA=0x1234. Over 4 slots, comm cycles E,D,B,7 with seg 66,4F,5B,06. comm=F for 2 cycles at the start of each slot.
- Read DATA after writing 0xDEAD_BEEF. iomem_ready pulses exactly once, 1 cycle after valid; rdata=0x0000_BEEF. Then write wstrb=4'b0010 wdata=0x0000_1200 → DATA=0x0000_12EF.
- Write DATA on the exact wrap cycle. The current slot shows the old nibble; the new value appears from the following slot. No glitch appears on seg while comm is active.
- CTRL=0x0000_0051 (EN, digits 0 and 2 masked): comm never drives bits 0 or 2 low. Then clear EN mid-slot: comm=F and seg=0 within 2 cycles, and STATUS reads 0.
- Assert resetn=0 for one cycle during an ON slot with a pending valid. Outputs return to their reset values; no ready is issued for the aborted request.
- With SEG7_DIM_EN and DUTY=3: in each ON phase, comm is active 4 of every 16 cycles. Without the macro, a CTRL read after writing 0xF01 returns 0x001.
